// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the streaming crossbar arbitration path.
package crossbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for a given source count; never narrower than one bit.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return (result < 1) ? 1 : result;
    endfunction

    // Packet quota of one source: a programmed zero still allows one packet.
    function automatic logic [31:0] packet_quota(input logic [31:0] weight);
        return (weight == 32'd0) ? 32'd1 : weight;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first requesting source at or after ptr, wrapping
// past the top index back to source 0.
module rr_priority_pick
    import crossbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 5,
    parameter int T_ID___WIDTH = clog2(S_DATA_COUNT)
) (
    input  logic [S_DATA_COUNT-1:0] request_mask,
    input  logic [T_ID___WIDTH-1:0] ptr,
    output logic                    found,
    output logic [S_DATA_COUNT-1:0] onehot,
    output logic [T_ID___WIDTH-1:0] index
);

    logic [T_ID___WIDTH-1:0] cand_idx [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] cand_req;

    genvar gi;

    // Candidate gi is the source gi places after ptr; ptr is always below S_DATA_COUNT.
    for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_cand
        logic [T_ID___WIDTH:0] sum;
        assign sum = {1'b0, ptr} + (T_ID___WIDTH+1)'(gi);
        assign cand_idx[gi] = (sum >= (T_ID___WIDTH+1)'(S_DATA_COUNT))
                            ? T_ID___WIDTH'(sum - (T_ID___WIDTH+1)'(S_DATA_COUNT))
                            : T_ID___WIDTH'(sum);
        assign cand_req[gi] = request_mask[cand_idx[gi]];
    end

    always_comb begin
        found = |cand_req;
        index = '0;
        for (int k = S_DATA_COUNT - 1; k >= 0; k--) begin
            if (cand_req[k]) index = cand_idx[k];
        end
    end

    for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_onehot
        assign onehot[gi] = found && (index == T_ID___WIDTH'(gi));
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Packet-level weighted round-robin arbiter: holds the grant for whole packets,
// up to a per-source packet quota, and re-arbitrates with no bubble on release.
module weighted_rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 5,
    parameter int T_ID___WIDTH = clog2(S_DATA_COUNT),
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [S_DATA_COUNT-1:0]              request_mask_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
    input  logic                                 m_ready_i,
    output logic [S_DATA_COUNT-1:0]              grant_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    output logic                                 m_valid_o,
    output logic                                 m_last_o
);

    arb_state_t              state_reg;
    logic [T_ID___WIDTH-1:0] ptr_reg;
    logic [T_ID___WIDTH-1:0] id_reg;
    logic [WEIGHT_WIDTH-1:0] credit_reg;
    logic                    first_beat_reg;
    logic [S_DATA_COUNT-1:0] grant_reg;

    logic [WEIGHT_WIDTH-1:0] weight_arr [S_DATA_COUNT];
    logic                    busy;
    logic                    handshake;
    logic                    last_handshake;
    logic                    forfeit;
    logic                    turn_done;
    logic [T_ID___WIDTH-1:0] release_ptr;
    logic [T_ID___WIDTH-1:0] pick_ptr;
    logic                    pick_found;
    logic [S_DATA_COUNT-1:0] pick_onehot;
    logic [T_ID___WIDTH-1:0] pick_index;
    logic [WEIGHT_WIDTH-1:0] pick_quota;

    genvar gi;
    for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_weight
        assign weight_arr[gi] = weight_i[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    assign busy      = (state_reg == BUSY);
    assign m_valid_o = busy & request_mask_i[id_reg];
    assign m_last_o  = busy & s_last_i[id_reg];
    assign grant_o   = grant_reg;
    assign m_id_o    = id_reg;

    assign handshake      = m_valid_o & m_ready_i;
    assign last_handshake = handshake & m_last_o;
    // A holder with nothing to send at a packet boundary gives up the rest of its turn.
    assign forfeit        = busy & first_beat_reg & ~request_mask_i[id_reg];
    assign turn_done      = forfeit | (last_handshake & (credit_reg <= WEIGHT_WIDTH'(1)));
    assign release_ptr    = (id_reg == T_ID___WIDTH'(S_DATA_COUNT - 1))
                          ? '0 : id_reg + T_ID___WIDTH'(1);
    assign pick_ptr       = turn_done ? release_ptr : ptr_reg;

    rr_priority_pick #(
        .S_DATA_COUNT (S_DATA_COUNT),
        .T_ID___WIDTH (T_ID___WIDTH)
    ) u_pick (
        .request_mask (request_mask_i),
        .ptr          (pick_ptr),
        .found        (pick_found),
        .onehot       (pick_onehot),
        .index        (pick_index)
    );

    assign pick_quota = WEIGHT_WIDTH'(packet_quota(32'(weight_arr[pick_index])));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            id_reg         <= '0;
            credit_reg     <= '0;
            first_beat_reg <= 1'b0;
            grant_reg      <= '0;
        end else if (state_reg == IDLE || turn_done) begin
            if (turn_done) ptr_reg <= release_ptr;
            if (pick_found) begin
                state_reg      <= BUSY;
                id_reg         <= pick_index;
                grant_reg      <= pick_onehot;
                credit_reg     <= pick_quota;
                first_beat_reg <= 1'b1;
            end else begin
                state_reg      <= IDLE;
                grant_reg      <= '0;
                credit_reg     <= '0;
                first_beat_reg <= 1'b0;
            end
        end else if (last_handshake) begin
            credit_reg     <= credit_reg - WEIGHT_WIDTH'(1);
            first_beat_reg <= 1'b1;
        end else if (handshake) begin
            first_beat_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed vector table, then randomized traffic
// checked against a packet-level behavioural model.
module tb_weighted_rr_arbiter;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int WW = 4;

    localparam logic [N*WW-1:0] W1 = 20'h11111;
    localparam logic [N*WW-1:0] W0 = 20'h11113;
    localparam logic [N*WW-1:0] W2 = 20'h11211;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    request_mask_i = '0;
    logic [N-1:0]    s_last_i = '0;
    logic [N*WW-1:0] weight_i = W1;
    logic            m_ready_i = 1'b1;
    logic [N-1:0]    grant_o;
    logic [IW-1:0]   m_id_o;
    logic            m_valid_o;
    logic            m_last_o;

    always #5 clk = ~clk;

    weighted_rr_arbiter #(
        .S_DATA_COUNT (N),
        .T_ID___WIDTH (IW),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .request_mask_i (request_mask_i),
        .s_last_i       (s_last_i),
        .weight_i       (weight_i),
        .m_ready_i      (m_ready_i),
        .grant_o        (grant_o),
        .m_id_o         (m_id_o),
        .m_valid_o      (m_valid_o),
        .m_last_o       (m_last_o)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Model: owner of the turn, packets left in the turn, where the next search starts.
    bit m_known = 0;
    bit m_busy  = 0;
    bit m_fresh = 0;
    int m_owner = 0;
    int m_left  = 0;
    int m_start = 0;

    function automatic int choose(input logic [N-1:0] mask, input int start);
        for (int d = 0; d < N; d++) begin
            if (mask[(start + d) % N]) return (start + d) % N;
        end
        return -1;
    endfunction

    task automatic take_turn(input int src);
        int w;
        w = int'(weight_i[src*WW +: WW]);
        m_busy  = 1;
        m_owner = src;
        m_left  = (w == 0) ? 1 : w;
        m_fresh = 1;
    endtask

    task automatic model_step();
        int winner;
        bit done;
        if (rst) begin
            m_known = 1; m_busy = 0; m_fresh = 0;
            m_owner = 0; m_left = 0; m_start = 0;
        end else if (!m_busy) begin
            winner = choose(request_mask_i, m_start);
            if (winner >= 0) take_turn(winner);
        end else begin
            done = 0;
            if (m_fresh && !request_mask_i[m_owner]) begin
                done = 1;
            end else if (request_mask_i[m_owner] && m_ready_i) begin
                m_fresh = 0;
                if (s_last_i[m_owner]) begin
                    m_left--;
                    if (m_left == 0) done = 1;
                    else m_fresh = 1;
                end
            end
            if (done) begin
                m_start = (m_owner + 1) % N;
                winner  = choose(request_mask_i, m_start);
                if (winner >= 0) take_turn(winner);
                else begin m_busy = 0; m_fresh = 0; end
            end
        end
    endtask

    logic          obs_valid, obs_last;
    logic [N-1:0]  obs_grant;
    logic [IW-1:0] obs_id;

    task automatic cycle(input logic r, input logic [N-1:0] mask, input logic [N-1:0] last, input logic rdy);
        @(negedge clk);
        rst = r; request_mask_i = mask; s_last_i = last; m_ready_i = rdy;
        #1;
        obs_valid = m_valid_o;
        obs_last  = m_last_o;
        if (m_known) begin
            check("model valid", obs_valid, m_busy && mask[m_owner]);
            check("model last", obs_last, m_busy && last[m_owner]);
        end
        @(posedge clk);
        model_step();
        #1;
        obs_grant = grant_o;
        obs_id    = m_id_o;
        check("model grant", obs_grant, m_busy ? (32'd1 << m_owner) : 32'd0);
        if (m_busy || r) check("model id", obs_id, m_owner);
    endtask

    typedef struct {
        logic          r;
        logic [N-1:0]  mask;
        logic [N-1:0]  last;
        logic          rdy;
        logic [N*WW-1:0] weights;
        logic          chk_pre;
        logic          exp_valid;
        logic          exp_last;
        logic [N-1:0]  exp_grant;
        logic [IW-1:0] exp_id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [N-1:0] mask, input logic [N-1:0] last,
                                input logic rdy, input logic [N*WW-1:0] w, input logic chk,
                                input logic ev, input logic el, input logic [N-1:0] eg, input logic [IW-1:0] eid);
        vec_t v;
        v.r = r; v.mask = mask; v.last = last; v.rdy = rdy; v.weights = w;
        v.chk_pre = chk; v.exp_valid = ev; v.exp_last = el; v.exp_grant = eg; v.exp_id = eid;
        return v;
    endfunction

    initial begin
        int ids_w0[7];
        ids_w0 = '{0, 0, 1, 2, 3, 4, 0};

        // Single-source packet held, then release hands over to source 4.
        vecs.push_back(mk(1, 5'b00000, 5'b00000, 1, W1, 0, 0, 0, 5'h00, 0));
        vecs.push_back(mk(0, 5'b01000, 5'b00000, 1, W1, 1, 0, 0, 5'h08, 3));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 5'b01000, 5'b00000, 1, W1, 1, 1, 0, 5'h08, 3));
        vecs.push_back(mk(0, 5'b11111, 5'b01000, 1, W1, 1, 1, 1, 5'h10, 4));
        // Single-beat packets rotate every cycle with no bubble.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, W1, 1, 1, 1, 5'(1 << (k % N)), 3'(k % N)));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 1, W1, 1, 0, 0, 5'h00, 0));
        // Source 0 with quota 3.
        vecs.push_back(mk(1, 5'b00000, 5'b00000, 1, W1, 1, 0, 0, 5'h00, 0));
        vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, W0, 1, 0, 0, 5'h01, 0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, W0, 1, 1, 1, 5'(1 << ids_w0[k]), 3'(ids_w0[k])));
        // Forfeit of the second packet of a quota-2 turn.
        vecs.push_back(mk(1, 5'b00000, 5'b00000, 1, W2, 1, 0, 0, 5'h00, 0));
        vecs.push_back(mk(0, 5'b00100, 5'b00000, 1, W2, 1, 0, 0, 5'h04, 2));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, W2, 1, 1, 1, 5'h04, 2));
        vecs.push_back(mk(0, 5'b01000, 5'b00000, 1, W2, 1, 0, 0, 5'h08, 3));
        // Ready stall on the last beat, then release wraps past source 4.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 5'b01001, 5'b01000, 0, W2, 1, 1, 1, 5'h08, 3));
        vecs.push_back(mk(0, 5'b01001, 5'b01000, 1, W2, 1, 1, 1, 5'h01, 0));
        // Reset mid-packet, then arbitration restarts from source 0.
        vecs.push_back(mk(0, 5'b00001, 5'b00000, 1, W2, 1, 1, 0, 5'h01, 0));
        vecs.push_back(mk(1, 5'b00001, 5'b00000, 1, W2, 1, 1, 0, 5'h00, 0));
        vecs.push_back(mk(0, 5'b00110, 5'b00000, 1, W2, 1, 0, 0, 5'h02, 1));
        vecs.push_back(mk(0, 5'b00110, 5'b00000, 1, W2, 1, 1, 0, 5'h02, 1));

        foreach (vecs[i]) begin
            weight_i = vecs[i].weights;
            cycle(vecs[i].r, vecs[i].mask, vecs[i].last, vecs[i].rdy);
            $display("vec %0d: mask=%b last=%b rdy=%b grant=%b id=%0d valid=%b", i,
                     vecs[i].mask, vecs[i].last, vecs[i].rdy, obs_grant, obs_id, obs_valid);
            if (vecs[i].chk_pre) begin
                check($sformatf("vec[%0d] valid", i), obs_valid, vecs[i].exp_valid);
                check($sformatf("vec[%0d] last", i), obs_last, vecs[i].exp_last);
            end
            check($sformatf("vec[%0d] grant", i), obs_grant, vecs[i].exp_grant);
            if (vecs[i].exp_grant != '0 || vecs[i].r)
                check($sformatf("vec[%0d] id", i), obs_id, vecs[i].exp_id);
        end

        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] mask, last;
            logic r, rdy;
            if ($urandom_range(0, 29) == 0) weight_i = (N*WW)'($urandom);
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < N; b++) begin
                mask[b] = ($urandom_range(0, 3) != 0);
                last[b] = ($urandom_range(0, 2) == 0);
            end
            cycle(r, mask, last, rdy);
            $display("rnd %0d: rst=%b mask=%b last=%b rdy=%b grant=%b id=%0d", c,
                     r, mask, last, rdy, obs_grant, obs_id);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Packet-level weighted round-robin arbiter for the streaming crossbar: selects one of S_DATA_COUNT slave sources for a master port, holds the grant for whole packets (until the last beat is accepted), and lets each source keep the grant for up to a programmable number of consecutive packets before rotation. It sits in each master-side mux of the crossbar, driving the select/id path and gating valid/last toward the master. It adds a ready handshake, per-source weights, forfeit of idle turns and zero-bubble re-arbitration.

## Interface
- S_DATA_COUNT, 5, number of requesting sources (≥2)
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of source id
- WEIGHT_WIDTH, 4, width of each per-source packet quota
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- request_mask_i  in  S_DATA_COUNT  per-source valid/request (bit i = source i has a beat)
- s_last_i  in  S_DATA_COUNT  per-source last-beat flag
- weight_i  in  S_DATA_COUNT*WEIGHT_WIDTH  quota of source i in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 treated as 1
- m_ready_i  in  1  master accepts current beat
- grant_o  out  S_DATA_COUNT  one-hot registered grant, all-zero when idle
- m_id_o  out  T_ID___WIDTH  id of granted source (registered)
- m_valid_o  out  1  request_mask_i[m_id_o] while granted, else 0
- m_last_o  out  1  s_last_i[m_id_o] while granted, else 0

## Operation
- State: IDLE / BUSY; registers: ptr (next-highest-priority source), id, credit (WEIGHT_WIDTH bits), first_beat.
- Pick function: lowest-index set bit of request mask rotated to start at ptr (wrap at S_DATA_COUNT-1 → 0).
- IDLE: any request → BUSY, id = pick, credit = weight_i[pick] (0→1), first_beat = 1, grant_o = onehot(pick). No request → stay IDLE.
- BUSY, beat handshake = m_valid_o & m_ready_i; clears first_beat; m_valid_o low mid-packet is a stall, grant held.
- Last-beat handshake (m_last_o & handshake): credit decrements. If credit becomes 0: release — ptr = id+1 (wrapping), re-arbitrate the same cycle with that ptr over current request_mask_i; winner granted next cycle (zero bubble), none → IDLE. If credit > 0: keep grant, first_beat = 1.
- Forfeit: BUSY, first_beat = 1, request_mask_i[id] = 0 → release exactly as above (ptr = id+1, re-arbitrate same cycle).
- weight_i sampled only when a grant is loaded; changes mid-turn have no effect.
- s_last_i of non-granted sources ignored.

## Timing
- Reset values: grant_o 0, m_id_o 0, m_valid_o 0, m_last_o 0, state IDLE, ptr 0, credit 0, first_beat 0.
- Request in IDLE at cycle n → grant_o/m_id_o valid at n+1; m_valid_o/m_last_o combinational from inputs thereafter.
- Release at cycle n (last beat or forfeit) → next grant at n+1; released source is lowest priority in that pick and wins only if alone.
- rst mid-packet: all outputs 0 after the edge; in-flight packet abandoned; ptr back to 0.
- Single-beat packet (s_last_i high on first beat) is a complete packet.
- Wrap: id = S_DATA_COUNT-1 release → ptr = 0.

## Structure
- Shared package crossbar_pkg: state encoding (IDLE, BUSY), clog2 helper, weight-slice macro/function.
- One sub-module: rr_priority_pick (combinational rotate, find-first, one-hot + index out, parameterised by S_DATA_COUNT); instantiated once and used for both IDLE and release-time arbitration.

## Test plan
- Reset, request_mask 5'b01000, ready 1, weights all 1, s_last 0 → grant 5'h08, id 3, valid 1; held across 3 beats; s_last 5'b01000 → next cycle with all requesting, grant 5'h10 (id 4).
- All request, all weights 1, s_last all 1, ready 1 → grants rotate 0,1,2,3,4,0 on consecutive cycles, no bubble.
- weight_i source 0 = 3, others 1, all request, single-beat packets → ids 0,0,0,1,2,3,4,0.
- Grant to id 2 with weight 2; after first packet request_mask[2] drops → forfeit, next cycle id 3 (if requesting).
- m_ready_i low 4 cycles mid-packet with last asserted → grant, id, last held; no rotation until ready returns.
- rst asserted mid-packet → next cycle grant 0, valid 0, last 0; request 5'b00110 then → grant 5'h02 (ptr reset to 0).
